cla5_pipe_adder: RTL and testbench

Registered two-stage wrapper around the team's 5-bit carry-lookahead adder.
- Stage 1 is an operand register bank that captures A, B and CIN on a handshake.
- Stage 2 evaluates the CLA on the stage-1 registers and registers the sum, carry-out and signed overflow.
- An accumulate mode feeds the last completed sum back as operand B.
- The block sits directly downstream of the operand D-flip-flop bank and replaces the ad-hoc per-bit registers with a valid/ready pipeline.

---
 rtl/cla5_pkg.sv | 18 +
 rtl/cla5.sv | 46 ++++
 rtl/cla5_pipe_adder.sv | 119 +++++++++++
 tb/tb_cla5_pipe_adder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla5_pkg.sv
// cla5_pkg
// Shared definitions for the 5-bit carry-lookahead adder family.
//   CLA_W    : operand width handled by the lookahead equations
//   operand_t: one operand bus
//   result_t : registered adder result {cout, ovf, s}
package cla5_pkg;

    localparam int CLA_W = 5;

    typedef logic [CLA_W-1:0] operand_t;

    typedef struct packed {
        logic     cout;
        logic     ovf;
        operand_t s;
    } result_t;

endpackage

// File: rtl/cla5.sv
// cla5
// Purely combinational 5-bit carry-lookahead adder.
// Ports:
//   a, b  : operands
//   cin   : carry-in
//   s     : sum bits
//   cout  : carry out of bit 4 (c5)
//   c4    : carry into bit 4, exposed so callers can form signed overflow
module cla5
    import cla5_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    input  logic     cin,
    output operand_t s,
    output logic     cout,
    output logic     c4
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened to generate/propagate terms so no carry
    // depends on another carry; this is the lookahead structure.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
                | (p[4] & p[3] & p[2] & g[1])
                | (p[4] & p[3] & p[2] & p[1] & g[0])
                | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s    = p ^ c[CLA_W-1:0];
    assign cout = c[5];
    assign c4   = c[4];

endmodule

// File: rtl/cla5_pipe_adder.sv
// cla5_pipe_adder
// Two-stage valid/ready pipeline around cla5 with an accumulate mode.
// Stage 1 registers {a, b_sel, cin}; stage 2 registers {s, cout, ovf}.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   a, b, cin           : operands; b is replaced by the accumulator when acc=1
//   acc                 : use last completed sum as operand b
//   clr                 : synchronous clear of the accumulator
//   out_valid/out_ready : result handshake
//   s, cout, ovf        : registered sum, carry-out, signed overflow
module cla5_pipe_adder
    import cla5_pkg::*;
#(
    parameter int WIDTH = CLA_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             acc,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH != CLA_W) begin : g_width_check
        $error("cla5_pipe_adder: only WIDTH=5 is supported");
    end

    logic     s1_valid;
    operand_t s1_a;
    operand_t s1_b;
    logic     s1_cin;
    operand_t acc_q;
    result_t  res_q;
    result_t  s2_next;
    operand_t cla_s;
    logic     cla_cout;
    logic     cla_c4;
    logic     s2_en;
    logic     s1_en;
    logic     accept;
    operand_t b_sel;

    // Handshake: stage 2 moves when empty or drained; stage 1 moves when
    // empty or when stage 2 moves. An accumulate op must wait until any
    // older op has left stage 1 so that acc_q already holds its sum.
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en && !(acc && s1_valid);
    assign accept   = in_valid && in_ready;
    assign b_sel    = acc ? acc_q : b;

    cla5 u_cla (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .s    (cla_s),
        .cout (cla_cout),
        .c4   (cla_c4)
    );

    assign s2_next = '{cout: cla_cout, ovf: cla_c4 ^ cla_cout, s: cla_s};

    // Stage 1 operand bank: loads on accept, empties when its op moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b_sel;
            s1_cin   <= cin;
        end else if (s2_en) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 result register: result fields only change when a new op
    // arrives, so a stalled or emptied output keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                res_q <= s2_next;
            end
        end
    end

    // Accumulator follows each result entering stage 2; clr wins over that load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (s2_en && s1_valid) begin
            acc_q <= s2_next.s;
        end
    end

    assign s    = res_q.s;
    assign cout = res_q.cout;
    assign ovf  = res_q.ovf;

endmodule

// File: tb/tb_cla5_pipe_adder.sv
// tb_cla5_pipe_adder
// Self-checking bench for cla5_pipe_adder: directed scenarios plus random
// and exhaustive streams checked against an arithmetic reference model.
module tb_cla5_pipe_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a;
    logic [4:0] b;
    logic       cin;
    logic       acc;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] s;
    logic       cout;
    logic       ovf;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;

    logic [6:0] expQ[$];
    logic [6:0] gotQ[$];
    logic [4:0] accModel = '0;
    logic       holdPending = 1'b0;
    logic [6:0] heldVal = '0;

    cla5_pipe_adder #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .acc       (acc),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {ovf, cout, s}.
    function automatic logic [6:0] refAdd(input logic [4:0] x, input logic [4:0] y,
                                          input logic c);
        int u;
        int sv;
        logic o;
        u  = int'(x) + int'(y) + int'(c);
        sv = int'($signed(x)) + int'($signed(y)) + int'(c);
        o  = (sv > 15) || (sv < -16);
        return {o, u[5], u[4:0]};
    endfunction

    // Scoreboard: sampled mid-cycle, describing what the next rising edge does.
    always @(negedge clk) begin
        logic [6:0] expv;
        logic [6:0] r;
        if (!rst_n) begin
            expQ.delete();
            accModel    = '0;
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("held out_valid", out_valid, 1);
                checkOutput("held result", {ovf, cout, s}, heldVal);
            end
            holdPending = out_valid && !out_ready;
            heldVal     = {ovf, cout, s};
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious out_valid", out_valid, 0);
                end else begin
                    expv = expQ.pop_front();
                    checkOutput("scoreboard result", {ovf, cout, s}, expv);
                end
                gotQ.push_back({ovf, cout, s});
            end
            r = refAdd(a, acc ? accModel : b, cin);
            if (clr) accModel = '0;
            if (in_valid && in_ready) begin
                expQ.push_back(r);
                accModel = r[4:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] av, input logic [4:0] bv,
                                 input logic cv, input logic accv, input logic clrv,
                                 input logic ordy);
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = cv;
        acc       = accv;
        clr       = clrv;
        out_ready = ordy;
        #1;
    endtask

    // Holds an op on the input until accepted; returns the accept edge number.
    task automatic sendOp(input logic [4:0] av, input logic [4:0] bv, input logic cv,
                          input logic accv, input logic ordy, output int acceptCycle);
        int n;
        n = 0;
        applyStimulus(1'b1, av, bv, cv, accv, 1'b0, ordy);
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) checkOutput("accept timeout", in_ready, 1);
        step();
        acceptCycle = cycleCount;
        in_valid = 1'b0;
    endtask

    initial begin
        int         c0;
        int         c1;
        int         c2;
        int         startCycle;
        int         sent;
        int         guard;
        logic       took;
        logic [6:0] g;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       rc;
        logic       racc;
        logic [10:0] combo;

        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset s", s, 0);
        checkOutput("reset cout", cout, 0);
        checkOutput("reset ovf", ovf, 0);
        checkOutput("reset in_ready", in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic op and two-cycle latency
        sendOp(5'd13, 5'd9, 1'b0, 1'b0, 1'b1, c0);
        checkOutput("latency out_valid early", out_valid, 0);
        step();
        checkOutput("basic out_valid", out_valid, 1);
        checkOutput("basic s", s, 22);
        checkOutput("basic cout", cout, 0);
        checkOutput("basic ovf", ovf, 1);

        // Wrap-around, back to back
        sendOp(5'd31, 5'd1, 1'b0, 1'b0, 1'b1, c0);
        sendOp(5'd15, 5'd0, 1'b1, 1'b0, 1'b1, c1);
        checkOutput("wrap s", s, 0);
        checkOutput("wrap cout", cout, 1);
        checkOutput("wrap ovf", ovf, 0);
        step();
        checkOutput("cin s", s, 16);
        checkOutput("cin cout", cout, 0);
        checkOutput("cin ovf", ovf, 1);
        checkOutput("back-to-back accept", c1 - c0, 1);
        step();

        // Backpressure: two accepts, then stall while the first result holds
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp ready 0", in_ready, 1);
        step();
        applyStimulus(1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp ready 1", in_ready, 1);
        step();
        applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp ready 2", in_ready, 0);
        step();
        checkOutput("bp ready 3", in_ready, 0);
        checkOutput("bp first s", s, 3);
        sendOp(5'd5, 5'd6, 1'b1, 1'b0, 1'b1, c0);
        sendOp(5'd20, 5'd20, 1'b0, 1'b0, 1'b1, c1);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        // Accumulate 7, 14, 21 with one bubble between accepts
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        clr = 1'b0;
        gotQ.delete();
        sendOp(5'd7, 5'd30, 1'b0, 1'b1, 1'b1, c0);
        sendOp(5'd7, 5'd30, 1'b0, 1'b1, 1'b1, c1);
        sendOp(5'd7, 5'd30, 1'b0, 1'b1, 1'b1, c2);
        checkOutput("acc bubble 1", c1 - c0, 2);
        checkOutput("acc bubble 2", c2 - c1, 2);
        for (int i = 0; i < 3; i++) step();
        checkOutput("acc count", gotQ.size(), 3);
        if (gotQ.size() == 3) begin
            g = gotQ.pop_front(); checkOutput("acc 7", g[4:0], 7);
            g = gotQ.pop_front(); checkOutput("acc 14", g[4:0], 14);
            g = gotQ.pop_front(); checkOutput("acc 21", g[4:0], 21);
        end

        // Clear on the edge where the 14 completes overrides the load
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        clr = 1'b0;
        gotQ.delete();
        sendOp(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, c0);
        sendOp(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, c1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        sendOp(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, c2);
        for (int i = 0; i < 3; i++) step();
        checkOutput("clr count", gotQ.size(), 3);
        if (gotQ.size() == 3) begin
            g = gotQ.pop_front(); checkOutput("clr seq 7", g[4:0], 7);
            g = gotQ.pop_front(); checkOutput("clr seq 14", g[4:0], 14);
            g = gotQ.pop_front(); checkOutput("clr seq after clear", g[4:0], 7);
        end

        // Reset in the middle of an op
        sendOp(5'd3, 5'd4, 1'b0, 1'b0, 1'b1, c0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", out_valid, 0);
        checkOutput("midreset s", s, 0);
        checkOutput("midreset in_ready", in_ready, 1);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("no stale result", out_valid, 0);
        end
        checkOutput("post reset in_ready", in_ready, 1);
        gotQ.delete();
        sendOp(5'd1, 5'd9, 1'b0, 1'b1, 1'b1, c0);
        step();
        checkOutput("acc cleared by reset", s, 1);
        step();

        // Random stream with random backpressure and accumulate ops
        sent  = 0;
        guard = 0;
        ra = 5'($urandom); rb = 5'($urandom); rc = 1'($urandom);
        racc = ($urandom_range(0, 3) == 0);
        while (sent < 400 && guard < 5000) begin
            applyStimulus(($urandom_range(0, 4) != 0), ra, rb, rc, racc, 1'b0,
                          ($urandom_range(0, 3) != 0));
            took = in_valid && in_ready;
            step();
            guard++;
            if (took) begin
                sent++;
                ra = 5'($urandom); rb = 5'($urandom); rc = 1'($urandom);
                racc = ($urandom_range(0, 3) == 0);
            end
        end
        checkOutput("random ops sent", sent, 400);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        // Exhaustive at full rate
        startCycle = cycleCount;
        for (int i = 0; i < 2048; i++) begin
            combo = 11'(i);
            sendOp(combo[4:0], combo[9:5], combo[10], 1'b0, 1'b1, c0);
        end
        checkOutput("full rate cycles", cycleCount - startCycle, 2048);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
